fetch_inst_queue: RTL and testbench

- Circular instruction buffer between fetch and decode/dispatch.
- Decouples I-cache return timing from rename/dispatch stalls.
- Accepts fetched {pc, inst, branch prediction} tuples and presents them in order to decode.
- Decode builds the if_id/id_ex payloads from the entry at the head.
- Flushed wholesale on branch mispredict or ROB redirect.

---
 rtl/rv32i_types.sv | 31 +++
 rtl/fetch_inst_queue.sv | 98 +++++++++
 tb/tb_fetch_inst_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
// Holds the fetch-to-decode instruction queue entry so that fetch, the
// instruction queue and decode all agree on one payload layout.
package rv32i_types;

    // Width of one packed queue entry: pc + inst + branch_pred + predicted_pc.
    localparam int INST_QUEUE_ENTRY_W = 97;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        branch_pred;
        logic [31:0] predicted_pc;
    } inst_queue_entry_t;

    // Assemble a queue entry from the individual fetch-side fields.
    function automatic inst_queue_entry_t make_inst_queue_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        branch_pred,
        input logic [31:0] predicted_pc
    );
        inst_queue_entry_t e;
        e.pc           = pc;
        e.inst         = inst;
        e.branch_pred  = branch_pred;
        e.predicted_pc = predicted_pc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
// Circular instruction buffer between fetch and decode. Fetch pushes
// {pc, inst, branch prediction, predicted pc} tuples; decode reads the head
// entry combinationally and pops it with deq_ready. The whole queue is
// discarded in one cycle on flush (mispredict / ROB redirect).
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   flush                 - empty the queue on the next edge
//   enq_valid/enq_ready   - fetch-side handshake
//   enq_pc/inst/branch_pred/predicted_pc - fetch payload
//   deq_valid/deq_ready   - decode-side handshake
//   deq_pc/inst/branch_pred/predicted_pc - head payload (valid only with deq_valid)
//   count                 - occupancy, 0..DEPTH
module fetch_inst_queue
    import rv32i_types::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_inst,
    input  logic             enq_branch_pred,
    input  logic [31:0]      enq_predicted_pc,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_inst,
    output logic             deq_branch_pred,
    output logic [31:0]      deq_predicted_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

    inst_queue_entry_t mem_r [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]    head_r;
    logic [PTR_W:0]    tail_r;

    logic              empty_s;
    logic              full_s;
    logic              enq_fire_s;
    logic              deq_fire_s;
    inst_queue_entry_t head_entry_s;

    // Status, handshakes and head read-out, all from registered pointers only.
    always_comb begin
        empty_s      = (head_r == tail_r);
        full_s       = (head_r[PTR_W-1:0] == tail_r[PTR_W-1:0]) &&
                       (head_r[PTR_W] != tail_r[PTR_W]);
        enq_ready    = !full_s;
        deq_valid    = !empty_s;
        enq_fire_s   = enq_valid && !full_s;
        deq_fire_s   = deq_ready && !empty_s;
        count        = tail_r - head_r;
        head_entry_s = mem_r[head_r[PTR_W-1:0]];
    end

    assign deq_pc           = head_entry_s.pc;
    assign deq_inst         = head_entry_s.inst;
    assign deq_branch_pred  = head_entry_s.branch_pred;
    assign deq_predicted_pc = head_entry_s.predicted_pc;

    // Pointer update: reset beats flush, flush discards any same-cycle enq/deq.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
        end else if (flush) begin
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
        end else begin
            if (enq_fire_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (deq_fire_s) begin
                head_r <= head_r + PTR_ONE;
            end
        end
    end

    // Storage write; the array itself is never reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq_fire_s) begin
            mem_r[tail_r[PTR_W-1:0]] <= make_inst_queue_entry(
                enq_pc, enq_inst, enq_branch_pred, enq_predicted_pc);
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed self-checking bench for fetch_inst_queue with DEPTH=4.
module tb_fetch_inst_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_pc;
    logic [31:0]      enq_inst;
    logic             enq_branch_pred;
    logic [31:0]      enq_predicted_pc;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_pc;
    logic [31:0]      deq_inst;
    logic             deq_branch_pred;
    logic [31:0]      deq_predicted_pc;
    logic [PTR_W:0]   count;

    int errors = 0;
    int checks = 0;

    fetch_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .enq_valid        (enq_valid),
        .enq_ready        (enq_ready),
        .enq_pc           (enq_pc),
        .enq_inst         (enq_inst),
        .enq_branch_pred  (enq_branch_pred),
        .enq_predicted_pc (enq_predicted_pc),
        .deq_valid        (deq_valid),
        .deq_ready        (deq_ready),
        .deq_pc           (deq_pc),
        .deq_inst         (deq_inst),
        .deq_branch_pred  (deq_branch_pred),
        .deq_predicted_pc (deq_predicted_pc),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already set, advance through posedge to the next negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                           input logic bp, input logic [31:0] ppc);
        enq_valid        = v;
        enq_pc           = pc;
        enq_inst         = inst;
        enq_branch_pred  = bp;
        enq_predicted_pc = ppc;
    endtask

    initial begin
        logic [31:0] p0;
        rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count",     {29'd0, count}, 32'd0);
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
        tick();
        chk("idle_count",     {29'd0, count}, 32'd0);
        chk("idle_deq_valid", {31'd0, deq_valid}, 32'd0);

        // Single enqueue, visible next cycle
        set_enq(1'b1, 32'h1eceb000, 32'h00000013, 1'b0, 32'h1eceb004);
        chk("same_cycle_no_bypass", {31'd0, deq_valid}, 32'd0);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("one_deq_valid", {31'd0, deq_valid}, 32'd1);
        chk("one_deq_pc",    deq_pc, 32'h1eceb000);
        chk("one_deq_inst",  deq_inst, 32'h00000013);
        chk("one_count",     {29'd0, count}, 32'd1);

        // Empty it, then fill to DEPTH
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush1_count", {29'd0, count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 32'h1eceb000 + 32'(4*i), 32'h00000013, 1'b0, 32'h0);
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("full_enq_ready", {31'd0, enq_ready}, 32'd0);
        chk("full_count",     {29'd0, count}, 32'd4);
        chk("full_head_pc",   deq_pc, 32'h1eceb000);

        // 5th enqueue while full with simultaneous deq: no pass-through
        set_enq(1'b1, 32'h1eceb010, 32'h00000013, 1'b0, 32'h0);
        deq_ready = 1'b1;
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        deq_ready = 1'b0;
        chk("full_deq_count",   {29'd0, count}, 32'd3);
        chk("full_deq_head_pc", deq_pc, 32'h1eceb004);

        // Drain: rejected entry must not show up
        deq_ready = 1'b1;
        tick();
        chk("drain_pc_b008", deq_pc, 32'h1eceb008);
        tick();
        chk("drain_pc_b00c", deq_pc, 32'h1eceb00c);
        tick();
        deq_ready = 1'b0;
        chk("drain_count",     {29'd0, count}, 32'd0);
        chk("drain_deq_valid", {31'd0, deq_valid}, 32'd0);

        // Continuous stream: one entry primed, then enq+deq every cycle
        p0 = 32'h1eceb020;
        set_enq(1'b1, p0, p0 ^ 32'ha5a5a5a5, 1'b0, p0 + 32'd4);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_enq(1'b1, p0 + 32'(4*(i+1)), (p0 + 32'(4*(i+1))) ^ 32'ha5a5a5a5, 1'b0, 32'h0);
            deq_ready = 1'b1;
            chk("stream_count", {29'd0, count}, 32'd1);
            chk("stream_pc",    deq_pc, p0 + 32'(4*i));
            chk("stream_inst",  deq_inst, (p0 + 32'(4*i)) ^ 32'ha5a5a5a5);
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        deq_ready = 1'b0;
        chk("stream_end_count", {29'd0, count}, 32'd1);
        chk("stream_end_pc",    deq_pc, p0 + 32'd80);

        // Build count=3, then flush with enq and deq both asserted
        set_enq(1'b1, 32'h1eceb0a0, 32'h0, 1'b0, 32'h0); tick();
        set_enq(1'b1, 32'h1eceb0a4, 32'h0, 1'b0, 32'h0); tick();
        chk("preflush_count", {29'd0, count}, 32'd3);
        flush = 1'b1; deq_ready = 1'b1;
        set_enq(1'b1, 32'h1eceb0a8, 32'h0, 1'b0, 32'h0);
        chk("flush_cycle_count", {29'd0, count}, 32'd3);
        chk("flush_cycle_valid", {31'd0, deq_valid}, 32'd1);
        tick();
        flush = 1'b0; deq_ready = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("postflush_count", {29'd0, count}, 32'd0);
        chk("postflush_valid", {31'd0, deq_valid}, 32'd0);

        set_enq(1'b1, 32'h1eceb100, 32'h00100093, 1'b1, 32'h1eceb200);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("after_flush_pc",   deq_pc, 32'h1eceb100);
        chk("after_flush_inst", deq_inst, 32'h00100093);
        chk("after_flush_bp",   {31'd0, deq_branch_pred}, 32'd1);
        chk("after_flush_ppc",  deq_predicted_pc, 32'h1eceb200);
        chk("after_flush_count", {29'd0, count}, 32'd1);

        // Reset mid-operation with count=2 and a firing enqueue
        set_enq(1'b1, 32'h1eceb104, 32'h0, 1'b0, 32'h0); tick();
        chk("prerst_count", {29'd0, count}, 32'd2);
        rst = 1'b1;
        set_enq(1'b1, 32'h1eceb300, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("midrst_count",     {29'd0, count}, 32'd0);
        chk("midrst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("midrst_enq_ready", {31'd0, enq_ready}, 32'd1);
        tick();
        chk("midrst_stays_empty", {29'd0, count}, 32'd0);
        set_enq(1'b1, 32'h1eceb400, 32'h0, 1'b0, 32'h0);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("postrst_pc",    deq_pc, 32'h1eceb400);
        chk("postrst_count", {29'd0, count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
